lstm_cell_update: RTL and testbench
===================================

# lstm_cell_update

Sequential LSTM cell-state and hidden-output stage for the Q8.24 fixed-point LSTM datapath. It consumes the four gate activations and the previous cell state, computes c_t = f·c_prev + i·g, and computes h_t = o·tanh(c_t) through an instantiated `tanh` module (WIDTH=32). It sits directly around that activation: it is upstream of `tanh` because it feeds it c_t, and downstream of `tanh` because it consumes tanh(c_t). One shared signed multiplier is time-multiplexed by a small FSM, and valid/ready handshakes are used on both sides.

## Interface
Parameters:
- WIDTH, 32, data word width. The only supported value is 32, because `tanh` constants are 32-bit.
- FRAC, 24, number of fractional bits. 1.0 = 32'h01000000.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- i_valid  in  1  operand set presented.
- i_ready  out  1  block can accept operands. Equals (state == IDLE).
- i_f  in  WIDTH  forget gate, signed Q8.24.
- i_i  in  WIDTH  input gate, signed Q8.24.
- i_g  in  WIDTH  candidate value, signed Q8.24.
- i_o  in  WIDTH  output gate, signed Q8.24.
- i_c_prev  in  WIDTH  previous cell state, signed Q8.24.
- o_valid  out  1  o_c and o_h are valid. Equals (state == DONE).
- o_ready  in  1  downstream accepts the result.
- o_c  out  WIDTH  new cell state c_t (registered).
- o_h  out  WIDTH  new hidden output h_t (registered).

## Operation
- FSM states: IDLE, FC, IG, OT, DONE.
- IDLE:
  - i_ready = 1.
  - When i_valid is sampled high, latch i_f, i_i, i_g, i_o and i_c_prev into operand registers, then go to FC.
  - Input changes after acceptance are ignored.
- FC:
  - acc <= fmul(f, c_prev).
  - Go to IG.
- IG:
  - c_reg <= sadd(acc, fmul(i, g)).
  - Go to OT.
- OT:
  - h_reg <= fmul(o, tanh(c_reg)).
  - Go to DONE.
- DONE:
  - o_valid = 1; o_c and o_h are held stable.
  - When o_ready is sampled high, go to IDLE.
  - i_ready = 0 until IDLE is re-entered. There is no accept in the same cycle as a result handoff.
- fmul(a, b):
  - Full 2·WIDTH-bit signed product.
  - Arithmetic shift right by FRAC, truncating toward −∞.
  - Saturate to [32'h80000000, 32'h7FFFFFFF].
- sadd(a, b):
  - WIDTH+1-bit signed sum, saturated to the same range.
- tanh:
  - Combinational on c_reg, via the existing `tanh` module.
  - Piecewise behaviour on |x|:
    - |x| < 0.5: result is x.
    - 0.5 ≤ |x| < 1: result is ±(|x|/2 + 0.25).
    - 1 ≤ |x| < 2: result is ±(|x|/4 + 0.5).
    - |x| ≥ 2: result is ±1.0.
- o_c mirrors c_reg and o_h mirrors h_reg. Neither changes outside the IG and OT states respectively.
- Reset:
  - state = IDLE; operand registers, acc, c_reg and h_reg = 0.
  - Therefore o_valid = 0, o_c = 0, o_h = 0, i_ready = 1.
  - Reset asserted mid-operation (any state) aborts the operation immediately, without waiting for a clock edge. No partial result is ever flagged valid.

## Timing
- Latency: o_valid rises 3 clock edges after the accepting edge (edge k accepts; o_valid is high from edge k+3).
- Throughput: at best one result every 5 cycles (accept, FC, IG, OT, DONE with o_ready = 1).
- Critical path:
  - Path 1: the 32×32 multiplier, then shift and saturate, then register.
  - Path 2 (OT): c_reg → tanh → multiplier → h_reg.
  - Neither path is pipelined.
- Handshake rules:
  - i_valid/i_ready transfer on an edge where both are high.
  - o_valid/o_ready transfer likewise.
  - o_valid, once high, stays high with stable data until the transfer occurs.
- Simultaneous rst with either handshake: rst wins.

## Test plan
- Nominal:
  - Stimulus: f = 32'h01000000, c_prev = 32'h00800000, i = g = 32'h00800000, o = 32'h01000000.
  - Response: o_c = 32'h00C00000, tanh = 32'h00A00000, o_h = 32'h00A00000; o_valid rises exactly 3 edges after acceptance.
- Saturation:
  - Stimulus: f = c_prev = 32'h40000000, i = g = 32'h01000000, o = 32'h00800000.
  - Response: o_c = 32'h7FFFFFFF, o_h = 32'h00800000.
- Negative value and rounding:
  - Stimulus A: f = 0, i = 32'h01000000, g = 32'hFF800000, o = 32'h01000000.
  - Response A: o_c = 32'hFF800000, o_h = 32'hFF800000.
  - Stimulus B: f = 32'hFFFFFFFF, c_prev = 1, i = g = 0.
  - Response B: o_c = 32'hFFFFFFFF (floor, not 0).
- Backpressure:
  - Stimulus: hold o_ready = 0 for 5 cycles in DONE while i_valid = 1 with new operands; then raise o_ready.
  - Response: i_ready stays 0, o_c/o_h stay unchanged, no second acceptance. After o_ready = 1, IDLE is entered on the next edge and the second set is accepted on the following edge.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously while in IG.
  - Response: o_valid = 0, o_c = 0, o_h = 0 before the next clock edge; i_ready = 1 after release; a fresh operation completes correctly.

Source files
------------

// File: rtl/lstm_cell_update_if.sv
// Operand/result handshake bundle for the LSTM cell-update stage.
// master drives operands and o_ready; slave is the datapath.
interface lstm_cell_update_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             i_ready;
    logic [WIDTH-1:0] i_f;
    logic [WIDTH-1:0] i_i;
    logic [WIDTH-1:0] i_g;
    logic [WIDTH-1:0] i_o;
    logic [WIDTH-1:0] i_c_prev;
    logic             o_valid;
    logic             o_ready;
    logic [WIDTH-1:0] o_c;
    logic [WIDTH-1:0] o_h;

    modport master (
        output i_valid, i_f, i_i, i_g, i_o, i_c_prev, o_ready,
        input  i_ready, o_valid, o_c, o_h
    );

    modport slave (
        input  i_valid, i_f, i_i, i_g, i_o, i_c_prev, o_ready,
        output i_ready, o_valid, o_c, o_h
    );
endinterface

// File: rtl/lstm_cell_update.sv
// LSTM cell-state / hidden-output stage, Q8.24, one shared multiplier.
// c_t = f*c_prev + i*g ; h_t = o*tanh(c_t), sequenced by a 5-state FSM.

// Piecewise-linear tanh on a signed Q8.24 word.
module tanh #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);
    localparam logic [WIDTH:0]   HALF = (WIDTH+1)'(32'h00800000);
    localparam logic [WIDTH:0]   ONE  = (WIDTH+1)'(32'h01000000);
    localparam logic [WIDTH:0]   TWO  = (WIDTH+1)'(32'h02000000);
    localparam logic [WIDTH-1:0] QTR  = WIDTH'(32'h00400000);
    localparam logic [WIDTH-1:0] HLF  = WIDTH'(32'h00800000);
    localparam logic [WIDTH-1:0] UNIT = WIDTH'(32'h01000000);

    logic [WIDTH:0]   mag;
    logic [WIDTH-1:0] r;

    // Magnitude is one bit wider so the most negative input is exact.
    always_comb begin
        mag = x[WIDTH-1] ? ((WIDTH+1)'(0) - {x[WIDTH-1], x}) : {1'b0, x};
        if (mag < HALF)
            r = mag[WIDTH-1:0];
        else if (mag < ONE)
            r = mag[WIDTH:1] + QTR;
        else if (mag < TWO)
            r = {1'b0, mag[WIDTH:2]} + HLF;
        else
            r = UNIT;
        y = x[WIDTH-1] ? (WIDTH'(0) - r) : r;
    end
endmodule

module lstm_cell_update #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input logic                clk,
    input logic                rst,
    lstm_cell_update_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FC   = 3'd1,
        IG   = 3'd2,
        OT   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] f_q, f_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic [WIDTH-1:0] o_q, o_d;
    logic [WIDTH-1:0] cp_q, cp_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] h_q, h_d;

    logic [WIDTH-1:0]         tanh_y;
    logic [WIDTH-1:0]         mul_a, mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;
    logic [WIDTH-1:0]         mul_res;
    logic [WIDTH:0]           sum;
    logic [WIDTH-1:0]         add_res;

    tanh #(.WIDTH(WIDTH)) u_tanh (
        .x (c_q),
        .y (tanh_y)
    );

    // State register; reset aborts any in-flight operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.i_valid) state_d = FC;
            FC:      state_d = IG;
            IG:      state_d = OT;
            OT:      state_d = DONE;
            DONE:    if (bus.o_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        bus.i_ready = (state_q == IDLE);
        bus.o_valid = (state_q == DONE);
    end

    // Shared multiplier operand select, then floor-shift and saturate.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            FC:      begin mul_a = f_q; mul_b = cp_q;   end
            IG:      begin mul_a = i_q; mul_b = g_q;    end
            OT:      begin mul_a = o_q; mul_b = tanh_y; end
            default: begin mul_a = '0;  mul_b = '0;     end
        endcase
        prod    = $signed({{WIDTH{mul_a[WIDTH-1]}}, mul_a})
                * $signed({{WIDTH{mul_b[WIDTH-1]}}, mul_b});
        prod_sh = prod >>> FRAC;
        if (prod_sh[2*WIDTH-1:WIDTH-1] == '0 ||
            prod_sh[2*WIDTH-1:WIDTH-1] == '1)
            mul_res = prod_sh[WIDTH-1:0];
        else if (prod_sh[2*WIDTH-1])
            mul_res = {1'b1, {(WIDTH-1){1'b0}}};
        else
            mul_res = {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Saturating add of f*c_prev and i*g.
    always_comb begin
        sum = {acc_q[WIDTH-1], acc_q} + {mul_res[WIDTH-1], mul_res};
        if (sum[WIDTH] == sum[WIDTH-1])
            add_res = sum[WIDTH-1:0];
        else if (sum[WIDTH])
            add_res = {1'b1, {(WIDTH-1){1'b0}}};
        else
            add_res = {1'b0, {(WIDTH-1){1'b1}}};
    end

    // Datapath next values: latch operands, accumulate, write results.
    always_comb begin
        f_d   = f_q;
        i_d   = i_q;
        g_d   = g_q;
        o_d   = o_q;
        cp_d  = cp_q;
        acc_d = acc_q;
        c_d   = c_q;
        h_d   = h_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    f_d  = bus.i_f;
                    i_d  = bus.i_i;
                    g_d  = bus.i_g;
                    o_d  = bus.i_o;
                    cp_d = bus.i_c_prev;
                end
            end
            FC:      acc_d = mul_res;
            IG:      c_d   = add_res;
            OT:      h_d   = mul_res;
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q   <= '0;
            i_q   <= '0;
            g_q   <= '0;
            o_q   <= '0;
            cp_q  <= '0;
            acc_q <= '0;
            c_q   <= '0;
            h_q   <= '0;
        end else begin
            f_q   <= f_d;
            i_q   <= i_d;
            g_q   <= g_d;
            o_q   <= o_d;
            cp_q  <= cp_d;
            acc_q <= acc_d;
            c_q   <= c_d;
            h_q   <= h_d;
        end
    end

    assign bus.o_c = c_q;
    assign bus.o_h = h_q;
endmodule

// File: tb/tb_lstm_cell_update.sv
// Bench for lstm_cell_update: directed vectors, backpressure and
// mid-operation reset sequences, then random operands vs a model.
module tb_lstm_cell_update;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lstm_cell_update_if #(.WIDTH(32)) bus ();

    lstm_cell_update #(.WIDTH(32), .FRAC(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] f, i, g, o, cp;
        logic [31:0] exp_c, exp_h;
    } vec_t;

    vec_t vecs[4];

    // Reference arithmetic in plain 64-bit integers.
    function automatic logic [31:0] sat32(input longint v);
        if (v > 64'sd2147483647)  return 32'h7FFFFFFF;
        if (v < -64'sd2147483648) return 32'h80000000;
        return 32'(v);
    endfunction

    function automatic logic [31:0] m_fmul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> 24;
        return sat32(p);
    endfunction

    function automatic logic [31:0] m_sadd(input logic [31:0] a, input logic [31:0] b);
        return sat32(longint'($signed(a)) + longint'($signed(b)));
    endfunction

    function automatic logic [31:0] m_tanh(input logic [31:0] v);
        longint x, m, r;
        x = longint'($signed(v));
        m = (x < 0) ? -x : x;
        if (m < 64'h800000)       r = m;
        else if (m < 64'h1000000) r = m / 2 + 64'h400000;
        else if (m < 64'h2000000) r = m / 4 + 64'h800000;
        else                      r = 64'h1000000;
        return 32'((x < 0) ? -r : r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] f, i, g, o, cp);
        bus.i_f      = f;
        bus.i_i      = i;
        bus.i_g      = g;
        bus.i_o      = o;
        bus.i_c_prev = cp;
    endtask

    // Wait for o_valid after an accept; lat counts edges from the accept.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.o_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] f, i, g, o, cp,
                         output logic [31:0] c, output logic [31:0] h);
        int lat;
        int w;
        w = 0;
        while (!bus.i_ready && w < 12) begin
            @(negedge clk);
            w++;
        end
        chk({name, ".i_ready"}, 32'(bus.i_ready), 32'd1);
        drive(f, i, g, o, cp);
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        drive('0, '0, '0, '0, '0);
        wait_valid(lat);
        chk({name, ".latency"}, 32'(lat), 32'd3);
        c = bus.o_c;
        h = bus.o_h;
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.o_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] c, h, c0, h0, ec, eh;
        logic [31:0] f, i, g, o, cp;
        int lat;

        vecs[0] = '{"nominal", 32'h01000000, 32'h00800000, 32'h00800000,
                    32'h01000000, 32'h00800000, 32'h00C00000, 32'h00A00000};
        vecs[1] = '{"saturate", 32'h40000000, 32'h01000000, 32'h01000000,
                    32'h00800000, 32'h40000000, 32'h7FFFFFFF, 32'h00800000};
        vecs[2] = '{"negative", 32'h00000000, 32'h01000000, 32'hFF800000,
                    32'h01000000, 32'h12345678, 32'hFF800000, 32'hFF800000};
        vecs[3] = '{"floor", 32'hFFFFFFFF, 32'h00000000, 32'h00000000,
                    32'h01000000, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};

        bus.i_valid = 1'b0;
        bus.o_ready = 1'b0;
        drive('0, '0, '0, '0, '0);

        @(negedge clk);
        @(negedge clk);
        chk("rst.i_ready", 32'(bus.i_ready), 32'd1);
        chk("rst.o_valid", 32'(bus.o_valid), 32'd0);
        chk("rst.o_c", bus.o_c, 32'd0);
        chk("rst.o_h", bus.o_h, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            do_op(vecs[k].name, vecs[k].f, vecs[k].i, vecs[k].g,
                  vecs[k].o, vecs[k].cp, c, h);
            chk({vecs[k].name, ".o_c"}, c, vecs[k].exp_c);
            chk({vecs[k].name, ".o_h"}, h, vecs[k].exp_h);
        end

        // Backpressure: result held, second set waits for handoff.
        drive(32'h01000000, 32'h00800000, 32'h00800000, 32'h01000000, 32'h00800000);
        bus.i_valid = 1'b1;
        @(negedge clk);
        drive(32'h00800000, 32'h01000000, 32'h01800000, 32'hFF000000, 32'h02000000);
        wait_valid(lat);
        chk("bp.latency", 32'(lat), 32'd3);
        c0 = bus.o_c;
        h0 = bus.o_h;
        chk("bp.first_c", c0, 32'h00C00000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp.i_ready", 32'(bus.i_ready), 32'd0);
            chk("bp.o_valid", 32'(bus.o_valid), 32'd1);
            chk("bp.o_c_hold", bus.o_c, c0);
            chk("bp.o_h_hold", bus.o_h, h0);
        end
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.o_ready = 1'b0;
        chk("bp.idle_o_valid", 32'(bus.o_valid), 32'd0);
        chk("bp.idle_i_ready", 32'(bus.i_ready), 32'd1);
        @(negedge clk);
        bus.i_valid = 1'b0;
        chk("bp.accepted", 32'(bus.i_ready), 32'd0);
        wait_valid(lat);
        chk("bp.second_latency", 32'(lat), 32'd3);
        ec = m_sadd(m_fmul(32'h00800000, 32'h02000000), m_fmul(32'h01000000, 32'h01800000));
        eh = m_fmul(32'hFF000000, m_tanh(ec));
        chk("bp.second_c", bus.o_c, ec);
        chk("bp.second_h", bus.o_h, eh);
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.o_ready = 1'b0;

        // Asynchronous reset while in IG; prior result must be wiped.
        drive(32'h00400000, 32'h00C00000, 32'h00200000, 32'h01000000, 32'h00300000);
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.o_valid", 32'(bus.o_valid), 32'd0);
        chk("arst.o_c", bus.o_c, 32'd0);
        chk("arst.o_h", bus.o_h, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst.i_ready", 32'(bus.i_ready), 32'd1);
        chk("arst.o_valid_after", 32'(bus.o_valid), 32'd0);
        do_op("arst.fresh", 32'h01000000, 32'h00800000, 32'h00800000,
              32'h01000000, 32'h00800000, c, h);
        chk("arst.fresh_c", c, 32'h00C00000);
        chk("arst.fresh_h", h, 32'h00A00000);

        // Random operands against the model.
        for (int k = 0; k < 40; k++) begin
            f  = 32'($signed($urandom()) >>> $urandom_range(0, 8));
            i  = 32'($signed($urandom()) >>> $urandom_range(0, 8));
            g  = 32'($signed($urandom()) >>> $urandom_range(0, 8));
            o  = 32'($signed($urandom()) >>> $urandom_range(0, 8));
            cp = 32'($signed($urandom()) >>> $urandom_range(0, 8));
            ec = m_sadd(m_fmul(f, cp), m_fmul(i, g));
            eh = m_fmul(o, m_tanh(ec));
            do_op("rand", f, i, g, o, cp, c, h);
            chk("rand.o_c", c, ec);
            chk("rand.o_h", h, eh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
